// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue.
// Request bundle carried from producers into the regfile port.
`timescale 1ns/1ps
package wb_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  num;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_queue_if.sv
// Long-latency writeback handshake (valid/ready with payload).
// The producer drives the master side; the queue is the slave.
`timescale 1ns/1ps
interface wb_queue_if;
  import wb_pkg::*;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_W-1:0]  lsu_num;
  logic [DATA_W-1:0] lsu_data;

  modport master (
    output lsu_valid,
    output lsu_num,
    output lsu_data,
    input  lsu_ready
  );

  modport slave (
    input  lsu_valid,
    input  lsu_num,
    input  lsu_data,
    output lsu_ready
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of writeback requests with kill-by-num
// and a youngest-match lookup for two read ports.
`timescale 1ns/1ps
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_req_t                push_req,
  input  logic                   pop,
  input  logic                   kill_en,
  input  logic [REG_W-1:0]       kill_num,
  output wb_req_t                head_req,
  output logic                   empty,
  output logic                   full,
  input  logic [1:0][REG_W-1:0]  look_num,
  output logic [1:0]             look_hit,
  output logic [1:0][DATA_W-1:0] look_data
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t            mem_q [DEPTH];
  wb_req_t            mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W:0]     cnt_q, cnt_d;

  assign head_req = mem_q[head_q];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (PTR_W+1)'(DEPTH));

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    // Kill before push so a same-cycle enqueue to kill_num survives.
    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].num == kill_num) mem_d[i].valid = 1'b0;
      end
    end
    if (pop) head_d = head_q + 1'b1;
    if (push) begin
      mem_d[tail_q] = push_req;
      tail_d = tail_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Scan oldest to youngest; the last match found wins.
  always_comb begin
    look_hit  = '0;
    look_data = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (((PTR_W+1)'(i) < cnt_q) &&
            mem_q[head_q + PTR_W'(i)].valid &&
            (mem_q[head_q + PTR_W'(i)].num == look_num[p])) begin
          look_hit[p]  = 1'b1;
          look_data[p] = mem_q[head_q + PTR_W'(i)].data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/wb_queue.sv
// Writeback initiator: ALU path wins the regfile port, long-latency
// results wait in a FIFO; decode can forward uncommitted values.
`timescale 1ns/1ps
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_num,
  input  logic [DATA_W-1:0] alu_data,
  wb_queue_if.slave         lsu,
  output logic              rf_write_en,
  output logic [REG_W-1:0]  rf_write_num,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [REG_W-1:0]  read_num1,
  input  logic [REG_W-1:0]  read_num2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
);
  logic                   alu_go;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_empty;
  logic                   fifo_full;
  wb_req_t                push_req;
  wb_req_t                head_req;
  logic [1:0][REG_W-1:0]  look_num;
  logic [1:0]             look_hit;
  logic [1:0][DATA_W-1:0] look_data;
  logic [1:0]             fwd_hit;
  logic [1:0][DATA_W-1:0] fwd_data;

  logic              en_q, en_d;
  logic [REG_W-1:0]  num_q, num_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign alu_go        = alu_valid && (alu_num != REG_ZERO);
  assign lsu.lsu_ready = rst_n && !fifo_full;
  assign fifo_push     = lsu.lsu_valid && lsu.lsu_ready &&
                         (lsu.lsu_num != REG_ZERO);
  assign fifo_pop      = !alu_go && !fifo_empty;
  assign push_req      = '{valid: 1'b1,
                           num:   lsu.lsu_num,
                           data:  lsu.lsu_data};
  assign look_num      = {read_num2, read_num1};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_req  (push_req),
    .pop       (fifo_pop),
    .kill_en   (alu_go),
    .kill_num  (alu_num),
    .head_req  (head_req),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .look_num  (look_num),
    .look_hit  (look_hit),
    .look_data (look_data)
  );

  // A killed head is retired silently; num/data keep their last value.
  always_comb begin
    en_d   = 1'b0;
    num_d  = num_q;
    data_d = data_q;
    if (alu_go) begin
      en_d   = 1'b1;
      num_d  = alu_num;
      data_d = alu_data;
    end else if (fifo_pop && head_req.valid) begin
      en_d   = 1'b1;
      num_d  = head_req.num;
      data_d = head_req.data;
    end
  end

  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int p = 0; p < 2; p++) begin
      if (look_num[p] != REG_ZERO) begin
        if (look_hit[p]) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = look_data[p];
        end else if (en_q && (num_q == look_num[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = data_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      num_q  <= '0;
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      num_q  <= num_d;
      data_q <= data_d;
    end
  end

  assign rf_write_en   = en_q;
  assign rf_write_num  = num_q;
  assign rf_write_data = data_q;
  assign fwd_hit1      = fwd_hit[0];
  assign fwd_hit2      = fwd_hit[1];
  assign fwd_data1     = fwd_data[0];
  assign fwd_data2     = fwd_data[1];
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: arbitration, back-pressure,
// WAW kill, forwarding priority, reg 0 and reset.
`timescale 1ns/1ps
module tb_wb_queue;
  import wb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid;
  logic [REG_W-1:0]  alu_num;
  logic [DATA_W-1:0] alu_data;
  logic              rf_write_en;
  logic [REG_W-1:0]  rf_write_num;
  logic [DATA_W-1:0] rf_write_data;
  logic [REG_W-1:0]  read_num1;
  logic [REG_W-1:0]  read_num2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  int n_chk  = 0;
  int n_fail = 0;

  wb_queue_if lsu_if ();

  wb_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_num       (alu_num),
    .alu_data      (alu_data),
    .lsu           (lsu_if.slave),
    .rf_write_en   (rf_write_en),
    .rf_write_num  (rf_write_num),
    .rf_write_data (rf_write_data),
    .read_num1     (read_num1),
    .read_num2     (read_num2),
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input int n, input logic [31:0] d);
    alu_valid = v;
    alu_num   = REG_W'(n);
    alu_data  = d;
  endtask

  task automatic lsu(input logic v, input int n, input logic [31:0] d);
    lsu_if.lsu_valid = v;
    lsu_if.lsu_num   = REG_W'(n);
    lsu_if.lsu_data  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    read_num1 = '0;
    read_num2 = '0;
    alu(1'b0, 0, 32'h0);
    lsu(1'b0, 0, 32'h0);

    // reset then idle
    repeat (2) cyc();
    chk("rst_en",   rf_write_en,   32'd0);
    chk("rst_num",  rf_write_num,  32'd0);
    chk("rst_data", rf_write_data, 32'd0);
    chk("rst_rdy",  lsu_if.lsu_ready, 32'd0);
    rst_n     = 1'b1;
    read_num1 = 5'd5;
    #1;
    chk("rel_rdy", lsu_if.lsu_ready, 32'd1);
    chk("rel_hit", fwd_hit1, 32'd0);

    // ALU only
    alu(1'b1, 5, 32'hDEADBEEF);
    cyc();
    alu(1'b0, 0, 32'h0);
    #1;
    chk("alu_en",   rf_write_en,   32'd1);
    chk("alu_num",  rf_write_num,  32'd5);
    chk("alu_data", rf_write_data, 32'hDEADBEEF);
    chk("alu_hit",  fwd_hit1,      32'd1);
    chk("alu_fwd",  fwd_data1,     32'hDEADBEEF);
    cyc();
    chk("idle_en",  rf_write_en,   32'd0);
    chk("idle_num", rf_write_num,  32'd5);

    // back-pressure: ALU holds the port while LSU fills the FIFO
    alu(1'b1, 20, 32'hAAAA0014);
    for (int i = 1; i <= 4; i++) begin
      lsu(1'b1, i, 32'h100 + i);
      #1;
      chk("bp_rdy", lsu_if.lsu_ready, 32'd1);
      cyc();
    end
    lsu(1'b1, 6, 32'h106);
    read_num1 = 5'd3;
    #1;
    chk("bp_full",  lsu_if.lsu_ready, 32'd0);
    chk("bp_alu",   rf_write_num,     32'd20);
    chk("bp_fhit",  fwd_hit1,         32'd1);
    chk("bp_fdat",  fwd_data1,        32'h103);
    cyc();
    chk("bp_full2", lsu_if.lsu_ready, 32'd0);
    alu(1'b0, 0, 32'h0);
    lsu(1'b0, 0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("drain_en",   rf_write_en,   32'd1);
      chk("drain_num",  rf_write_num,  i);
      chk("drain_data", rf_write_data, 32'h100 + i);
      if (i == 1) chk("drain_rdy", lsu_if.lsu_ready, 32'd1);
    end
    cyc();
    chk("drain_end", rf_write_en, 32'd0);

    // WAW kill
    lsu(1'b1, 7, 32'h11);
    cyc();
    lsu(1'b0, 0, 32'h0);
    alu(1'b1, 7, 32'h22);
    read_num1 = 5'd7;
    #1;
    chk("waw_q", fwd_data1, 32'h11);
    cyc();
    alu(1'b0, 0, 32'h0);
    #1;
    chk("waw_en",   rf_write_en,   32'd1);
    chk("waw_num",  rf_write_num,  32'd7);
    chk("waw_data", rf_write_data, 32'h22);
    chk("waw_fwd",  fwd_data1,     32'h22);
    cyc();
    chk("waw_dead", rf_write_en,   32'd0);
    chk("waw_hold", rf_write_data, 32'h22);
    chk("waw_nohit", fwd_hit1,     32'd0);
    cyc();
    chk("waw_idle", rf_write_en,   32'd0);

    // same-cycle ALU and LSU to one register: LSU is younger
    lsu(1'b1, 12, 32'h33);
    alu(1'b1, 12, 32'h44);
    cyc();
    lsu(1'b0, 0, 32'h0);
    alu(1'b0, 0, 32'h0);
    read_num1 = 5'd12;
    #1;
    chk("same_data", rf_write_data, 32'h44);
    chk("same_fwd",  fwd_data1,     32'h33);
    cyc();
    chk("same_en2",  rf_write_en,   32'd1);
    chk("same_dat2", rf_write_data, 32'h33);
    cyc();
    chk("same_end",  rf_write_en,   32'd0);

    // forward priority among queued entries
    lsu(1'b1, 9, 32'hA);
    cyc();
    lsu(1'b1, 9, 32'hB);
    read_num1 = 5'd9;
    read_num2 = 5'd9;
    #1;
    chk("pri_q", fwd_data1, 32'hA);
    cyc();
    lsu(1'b0, 0, 32'h0);
    #1;
    chk("pri_enA",  rf_write_en,   32'd1);
    chk("pri_datA", rf_write_data, 32'hA);
    chk("pri_f1",   fwd_data1,     32'hB);
    chk("pri_f2",   fwd_data2,     32'hB);
    cyc();
    chk("pri_datB", rf_write_data, 32'hB);
    chk("pri_fB",   fwd_data1,     32'hB);
    cyc();
    chk("pri_end",  rf_write_en,   32'd0);

    // register 0 requests are dropped
    alu(1'b1, 0, 32'h55);
    lsu(1'b1, 0, 32'h66);
    read_num1 = 5'd0;
    read_num2 = 5'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("r0_rdy", lsu_if.lsu_ready, 32'd1);
      cyc();
      chk("r0_en",  rf_write_en, 32'd0);
      chk("r0_h1",  fwd_hit1,    32'd0);
      chk("r0_d1",  fwd_data1,   32'd0);
      chk("r0_h2",  fwd_hit2,    32'd0);
    end
    alu(1'b0, 0, 32'h0);
    lsu(1'b0, 0, 32'h0);
    cyc();
    chk("r0_rdy2", lsu_if.lsu_ready, 32'd1);
    chk("r0_idle", rf_write_en,      32'd0);

    // reset mid-operation discards the queue
    alu(1'b1, 20, 32'h77);
    lsu(1'b1, 1, 32'h201);
    cyc();
    lsu(1'b1, 2, 32'h202);
    cyc();
    lsu(1'b0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mr_rdy", lsu_if.lsu_ready, 32'd0);
    cyc();
    chk("mr_en",   rf_write_en,   32'd0);
    chk("mr_num",  rf_write_num,  32'd0);
    chk("mr_data", rf_write_data, 32'd0);
    rst_n = 1'b1;
    alu(1'b0, 0, 32'h0);
    #1;
    chk("mr_rel", lsu_if.lsu_ready, 32'd1);
    cyc();
    chk("mr_empty1", rf_write_en, 32'd0);
    cyc();
    chk("mr_empty2", rf_write_en, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
